// File: rtl/div_issue_ctrl.sv
// div_issue_ctrl: requester-side controller for the multi-cycle divider in EX.
//
// Takes DIV/DIVU/REM/REMU and their W forms from EX and drives the divider's
// valid, sign, 32-bit and operand inputs. It stalls EX while the divider runs,
// selects the quotient or the remainder, sign-extends W results and presents a
// single writeback pulse. The divider has no abort input, so a flush during an
// operation keeps div_valid high until the divider reports ready.
//
// Ports:
//   clk, rst        clock; asynchronous active-low reset
//   req_*           request from EX (op: [2]=W, [1]=REM, [0]=unsigned)
//   flush           kill the current EX op
//   stall_o         hold EX/upstream
//   wb_*            one-cycle writeback of the final result
//   div_*           divider handshake, operands and {remainder, quotient} result
//
// Optional feature: define DIV_RESULT_REUSE_EN to keep the last divider result
// and answer a repeated request (same operands, W and unsigned bits) without
// running the divider.

module div_issue_ctrl #(
  parameter int unsigned XLEN     = 64,
  parameter int unsigned RD_WIDTH = 5
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  input  logic [2:0]          req_op,
  input  logic [XLEN-1:0]     req_rs1,
  input  logic [XLEN-1:0]     req_rs2,
  input  logic [RD_WIDTH-1:0] req_rd,
  input  logic                flush,
  output logic                stall_o,
  output logic                wb_valid,
  output logic [RD_WIDTH-1:0] wb_rd,
  output logic [XLEN-1:0]     wb_data,
  output logic                div_valid,
  output logic                div_sign,
  output logic                div_32,
  output logic [XLEN-1:0]     div_rs1,
  output logic [XLEN-1:0]     div_rs2,
  input  logic                div_ready,
  input  logic [2*XLEN-1:0]   div_result
);

  typedef enum logic [1:0] {StIdle, StBusy, StDrain, StDone} state_e;

  state_e              state_q, state_d;
  logic [XLEN-1:0]     rs1_q, rs1_d, rs2_q, rs2_d, wb_data_q, wb_data_d;
  logic [2:0]          op_q, op_d;
  logic [RD_WIDTH-1:0] rd_q, rd_d;

  logic            accept;
  logic            busy_done;
  logic            reuse_hit;
  logic [XLEN-1:0] reuse_data;

  // Quotient/remainder select, with W results sign-extended from bit 31.
  function automatic logic [XLEN-1:0] sel_result(input logic [2:0]        op,
                                                 input logic [2*XLEN-1:0] res);
    logic [XLEN-1:0] sel;
    sel = op[1] ? res[2*XLEN-1:XLEN] : res[XLEN-1:0];
    if (op[2]) sel = {{(XLEN-32){sel[31]}}, sel[31:0]};
    return sel;
  endfunction

  assign accept    = (state_q == StIdle) && req_valid && !flush;
  assign busy_done = (state_q == StBusy) && div_ready && !flush;

`ifdef DIV_RESULT_REUSE_EN
  localparam int unsigned TagW = 2 * XLEN + 2;

  logic [2*XLEN-1:0] last_res_q, last_res_d;
  logic [TagW-1:0]   tag_q, tag_d;
  logic              tag_vld_q, tag_vld_d;

  // REM bit is not part of the tag: the stored result holds both halves.
  assign reuse_hit  = tag_vld_q && (tag_q == {req_rs1, req_rs2, req_op[2], req_op[0]});
  assign reuse_data = sel_result(req_op, last_res_q);

  always_comb begin
    last_res_d = last_res_q;
    tag_d      = tag_q;
    tag_vld_d  = tag_vld_q;
    if (busy_done) begin
      last_res_d = div_result;
      tag_d      = {rs1_q, rs2_q, op_q[2], op_q[0]};
      tag_vld_d  = 1'b1;
    end else if ((state_q == StBusy) && flush && !div_ready) begin
      tag_vld_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_res_q <= '0;
      tag_q      <= '0;
      tag_vld_q  <= 1'b0;
    end else begin
      last_res_q <= last_res_d;
      tag_q      <= tag_d;
      tag_vld_q  <= tag_vld_d;
    end
  end
`else
  assign reuse_hit  = 1'b0;
  assign reuse_data = '0;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= StIdle;
      rs1_q     <= '0;
      rs2_q     <= '0;
      op_q      <= '0;
      rd_q      <= '0;
      wb_data_q <= '0;
    end else begin
      state_q   <= state_d;
      rs1_q     <= rs1_d;
      rs2_q     <= rs2_d;
      op_q      <= op_d;
      rd_q      <= rd_d;
      wb_data_q <= wb_data_d;
    end
  end

  // Next state.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (accept) state_d = reuse_hit ? StDone : StBusy;
      StBusy: begin
        if (div_ready)  state_d = flush ? StIdle : StDone;
        else if (flush) state_d = StDrain;
      end
      // Valid must stay high until ready or the divider's counter stalls.
      StDrain: if (div_ready) state_d = StIdle;
      // Never relaunch here: req_valid in DONE is the same instruction retiring.
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Operand capture and result select.
  always_comb begin
    rs1_d     = rs1_q;
    rs2_d     = rs2_q;
    op_d      = op_q;
    rd_d      = rd_q;
    wb_data_d = wb_data_q;
    if (accept) begin
      rs1_d = req_rs1;
      rs2_d = req_rs2;
      op_d  = req_op;
      rd_d  = req_rd;
      if (reuse_hit) wb_data_d = reuse_data;
    end
    if (busy_done) wb_data_d = sel_result(op_q, div_result);
  end

  // Outputs.
  always_comb begin
    div_valid = (state_q == StBusy) || (state_q == StDrain);
    stall_o   = (state_q == StBusy) ||
                (req_valid && !flush && ((state_q == StIdle) || (state_q == StDrain)));
    wb_valid  = (state_q == StDone) && !flush;
  end

  // Divider operands come only from registers: the divider reads rs1 live on its
  // zero/overflow path, so these must not move during an operation.
  assign div_rs1  = rs1_q;
  assign div_rs2  = rs2_q;
  assign div_sign = ~op_q[0];
  assign div_32   = op_q[2];
  assign wb_rd    = rd_q;
  assign wb_data  = wb_data_q;

endmodule
